// File: rtl/demux_1_8_if.sv
// Producer/consumer bundle for the registered 1-to-8 demultiplexer.
// The producer drives word, select and enable; the demux returns eight lanes plus one-hot lane valids.
interface demux_1_8_if #(
  parameter int unsigned DATA_W = 1
);
  logic [DATA_W-1:0]   i;
  logic [2:0]          s;
  logic                en;
  logic [8*DATA_W-1:0] y;
  logic [7:0]          y_vld;

  modport master (output i, s, en, input y, y_vld);
  modport slave  (input i, s, en, output y, y_vld);
endinterface

// File: rtl/demux_1_8.sv
// Registered 1-to-8 demultiplexer: steers bus.i to lane bus.s with a one-hot valid, one clock of latency.
// Define DEMUX_1_8_HOLD_EN to make unselected lanes, and all lanes while en=0, keep their last value.
module demux_1_8 #(
  parameter int unsigned DATA_W = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  demux_1_8_if.slave bus
);
  localparam int unsigned LANES = 8;
  localparam int unsigned Y_W   = LANES * DATA_W;

  logic [Y_W-1:0]   y_q;
  logic [Y_W-1:0]   y_d;
  logic [LANES-1:0] vld_q;
  logic [LANES-1:0] vld_d;

  // Next-state lane contents and valid flags
  always_comb begin
`ifdef DEMUX_1_8_HOLD_EN
    y_d = y_q;
`else
    y_d = '0;
`endif
    vld_d = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (bus.en && (bus.s == 3'(k))) begin
        y_d[k*DATA_W +: DATA_W] = bus.i;
        vld_d[k]                = 1'b1;
      end
    end
  end

  // Reset wins over en/s on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      vld_q <= '0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.y_vld = vld_q;
endmodule

// File: tb/tb_demux_1_8.sv
// Directed bench for demux_1_8 at DATA_W=1 and DATA_W=8 sharing one stimulus stream.
// Expected outputs come from a reference model and wait in a queue until the edge that produces them.
module tb_demux_1_8;
  logic clk;
  logic rst_n;

  demux_1_8_if #(.DATA_W(1)) bus1 ();
  demux_1_8_if #(.DATA_W(8)) bus8 ();

  demux_1_8 #(.DATA_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  demux_1_8 #(.DATA_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  y1;
    logic [7:0]  v1;
    logic [63:0] y8;
    logic [7:0]  v8;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0]  m_y1 = '0;
  logic [63:0] m_y8 = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, then compare after the edge
  task automatic step(input string tag, input logic rst, input logic [2:0] sel, input logic ena,
                      input logic d1, input logic [7:0] d8);
    exp_t e;
    logic [7:0] vld;
    rst_n    = rst;
    bus1.i   = d1;
    bus1.s   = sel;
    bus1.en  = ena;
    bus8.i   = d8;
    bus8.s   = sel;
    bus8.en  = ena;
    vld = 8'h00;
    if (!rst) begin
      m_y1 = '0;
      m_y8 = '0;
    end else begin
`ifndef DEMUX_1_8_HOLD_EN
      m_y1 = '0;
      m_y8 = '0;
`endif
      if (ena) begin
        vld = 8'h01 << sel;
        m_y1[sel]         = d1;
        m_y8[sel*8 +: 8]  = d8;
      end
    end
    e.y1 = m_y1;
    e.v1 = vld;
    e.y8 = m_y8;
    e.v8 = vld;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_y1"},   64'(bus1.y),     64'(e.y1));
      check({tag, "_vld1"}, 64'(bus1.y_vld), 64'(e.v1));
      check({tag, "_y8"},   bus8.y,          e.y8);
      check({tag, "_vld8"}, 64'(bus8.y_vld), 64'(e.v8));
      check({tag, "_onehot"}, 64'($countones(bus1.y_vld) <= 1), 64'(1));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    bus1.i  = '0; bus1.s = '0; bus1.en = 1'b0;
    bus8.i  = '0; bus8.s = '0; bus8.en = 1'b0;
    @(negedge clk);

    step("reset0", 1'b0, 3'd5, 1'b1, 1'b1, 8'hFF);
    step("reset1", 1'b0, 3'd5, 1'b1, 1'b1, 8'hFF);

    for (int k = 0; k < 8; k++)
      step("walk", 1'b1, 3'(k), 1'b1, 1'b1, 8'(8'h11 * k + 1));

    step("en_on",  1'b1, 3'd3, 1'b1, 1'b1, 8'h3C);
    step("en_off", 1'b1, 3'd3, 1'b0, 1'b1, 8'h3C);

    step("lane6",  1'b1, 3'd6, 1'b1, 1'b1, 8'hA5);
    step("zero",   1'b1, 3'd2, 1'b1, 1'b0, 8'h00);

    step("stream1",   1'b1, 3'd1, 1'b1, 1'b1, 8'h5A);
    step("stream_rst", 1'b0, 3'd4, 1'b1, 1'b1, 8'hC3);

    for (int n = 0; n < 40; n++)
      step("rand", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
